// File: rtl/ram_stream_reader_pkg.sv
// Shared types and defaults for the ram64 read-side stream engine.
// Holds the FSM encoding and default RAM geometry.
package ram_stream_reader_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Block is empty when the requested word count is zero.
    function automatic logic is_empty(input logic [ADDR_WIDTH_DEF:0] cnt);
        return cnt == '0;
    endfunction

endpackage

// File: rtl/ram_stream_reader.sv
// Walks a block of ram64 addresses and streams each word out
// over a valid/ready port; read-only, never drives a write.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_load,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [CNT_W-1:0]        remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    empty_req;

    assign empty_req = (count == '0);

    // Next-state and next-output logic; the address register doubles
    // as the RAM address so the read in FETCH sees a stable address.
    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        remaining_d   = remaining_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mem_address_d = base;
                    remaining_d   = count;
                    state_d       = empty_req ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                out_data_d  = mem_out;
                out_valid_d = 1'b1;
                out_last_d  = (remaining_q == CNT_W'(1));
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        mem_address_d = mem_address_q + ADDR_WIDTH'(1);
                        state_d       = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset returns to an idle, quiet port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            remaining_q   <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            remaining_q   <= remaining_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_load    = 1'b0;
    assign mem_in      = '0;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a ram64 stand-in
// and a word-queue model of the expected stream.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  base = '0;
    logic [6:0]  count = '0;
    logic [5:0]  mem_address;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] mem [64];
    logic [16:0] exp_q [$];

    int n_checks = 0;
    int n_fail = 0;
    int hs_count = 0;

    bit          hold = 1'b0;
    logic [15:0] hold_data = '0;
    logic        hold_last = 1'b0;

    always #5 clk = ~clk;

    assign mem_out = mem[mem_address];

    ram_stream_reader dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base(base),
        .count(count),
        .mem_address(mem_address),
        .mem_load(mem_load),
        .mem_in(mem_in),
        .mem_out(mem_out),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected stream: consecutive words from base, wrapping at 64.
    task automatic push_model(input logic [5:0] b, input logic [6:0] c);
        for (int i = 0; i < int'(c); i++) begin
            logic [5:0] a;
            a = b + 6'(i);
            exp_q.push_back({(i == int'(c) - 1), mem[a]});
        end
    endtask

    // Per-cycle checker: invariants, hold stability, word order.
    always @(negedge clk) begin
        chk("mem_load_zero", mem_load, 0);
        chk("mem_in_zero", mem_in, 0);
        if (reset) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (done) chk("done_no_valid", out_valid, 0);
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
                chk("hold_last", out_last, hold_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("word_data", out_data, e[15:0]);
                    chk("word_last", out_last, e[16]);
                end
                hs_count++;
            end
            hold = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    task automatic run_block(input logic [5:0] b, input logic [6:0] c,
                             input bit slow, input bit spam);
        int hs0;
        bit seen;
        hs0 = hs_count;
        push_model(b, c);
        base = b;
        count = c;
        out_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            out_ready = slow ? (i % 3 != 0) : 1'b1;
            if (spam) begin
                start = 1'b1;
                base = 6'(i);
                count = 7'd5;
            end
            tick;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", seen, 1);
        chk("word_count", hs_count - hs0, c);
        chk("model_drained", exp_q.size(), 0);
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h5A00 + 16'(i);
        mem[6'h00] = 16'hABAB;
        mem[6'h3F] = 16'hCDCD;
        mem[6'h01] = 16'h1234;

        tick;
        tick;
        chk("rst_addr", mem_address, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick;

        // Two words from 0x00 with the consumer always ready.
        push_model(6'h00, 7'd2);
        base = 6'h00; count = 7'd2; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk("s1_busy", busy, 1);
        chk("s1_fetch_valid", out_valid, 0);
        chk("s1_addr0", mem_address, 6'h00);
        tick;
        chk("s1_v0", out_valid, 1);
        chk("s1_d0", out_data, 16'hABAB);
        chk("s1_l0", out_last, 0);
        tick;
        chk("s1_gap", out_valid, 0);
        chk("s1_addr1", mem_address, 6'h01);
        tick;
        chk("s1_d1", out_data, 16'h1234);
        chk("s1_l1", out_last, 1);
        tick;
        chk("s1_done", done, 1);
        chk("s1_done_busy", busy, 1);
        tick;
        chk("s1_done_clr", done, 0);
        chk("s1_idle", busy, 0);

        // Wrap from 0x3F to 0x00.
        push_model(6'h3F, 7'd2);
        base = 6'h3F; count = 7'd2; start = 1'b1;
        tick;
        start = 1'b0;
        chk("s2_addr3f", mem_address, 6'h3F);
        tick;
        chk("s2_d0", out_data, 16'hCDCD);
        tick;
        chk("s2_addr00", mem_address, 6'h00);
        tick;
        chk("s2_d1", out_data, 16'hABAB);
        chk("s2_l1", out_last, 1);
        tick;
        chk("s2_done", done, 1);
        tick;

        // Backpressure: word must hold while the consumer stalls.
        push_model(6'h00, 7'd1);
        base = 6'h00; count = 7'd1; out_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("s3_valid", out_valid, 1);
        chk("s3_data", out_data, 16'hABAB);
        chk("s3_last", out_last, 1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("s3_hold_valid", out_valid, 1);
            chk("s3_hold_data", out_data, 16'hABAB);
        end
        out_ready = 1'b1;
        tick;
        chk("s3_acc_valid", out_valid, 0);
        chk("s3_done", done, 1);
        tick;
        chk("s3_idle", busy, 0);

        // Empty block: straight to the done pulse.
        base = 6'h07; count = 7'd0; start = 1'b1;
        tick;
        start = 1'b0;
        chk("s4_busy", busy, 1);
        chk("s4_done", done, 1);
        chk("s4_valid", out_valid, 0);
        tick;
        chk("s4_busy_clr", busy, 0);
        chk("s4_done_clr", done, 0);

        // Reset while a word is being offered.
        push_model(6'h10, 7'd4);
        base = 6'h10; count = 7'd4; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("s5_in_send", out_valid, 1);
        reset = 1'b1;
        tick;
        chk("s5_addr", mem_address, 0);
        chk("s5_data", out_data, 0);
        chk("s5_valid", out_valid, 0);
        chk("s5_last", out_last, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        reset = 1'b0;
        tick;
        run_block(6'h3E, 7'd4, 1'b0, 1'b0);

        // Start requests while busy must be ignored.
        run_block(6'h20, 7'd3, 1'b0, 1'b1);

        // Full 64-word sweep with intermittent backpressure.
        run_block(6'h05, 7'd64, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
